// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with write-to-read bypass,
// hardwired-zero register 0, a per-register busy scoreboard and a sequential
// post-reset clear sequencer.
//
// Ports:
//   clk       clock
//   rst       synchronous, active-high reset; restarts the clear sequence
//   ready     high once every entry has been cleared; file usable
//   wen0/waddr0/wdata0  write port 0 (ALU writeback)
//   wen1/waddr1/wdata1  write port 1 (load writeback, wins on address clash)
//   set_en/set_addr     mark a destination register busy (instruction issue)
//   raddr     NRD packed read addresses, port i at [i*ASIZE +: ASIZE]
//   rdata     NRD packed read data, port i at [i*DSIZE +: DSIZE] (combinational)
//   rbusy     NRD hazard flags, one per read port (combinational)
module regfile_mp #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 5,
    parameter int NREG  = 32,
    parameter int NRD   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ready,
    input  logic                   wen0,
    input  logic [ASIZE-1:0]       waddr0,
    input  logic [DSIZE-1:0]       wdata0,
    input  logic                   wen1,
    input  logic [ASIZE-1:0]       waddr1,
    input  logic [DSIZE-1:0]       wdata1,
    input  logic                   set_en,
    input  logic [ASIZE-1:0]       set_addr,
    input  logic [NRD*ASIZE-1:0]   raddr,
    output logic [NRD*DSIZE-1:0]   rdata,
    output logic [NRD-1:0]         rbusy
);

    localparam int NADDR = 1 << ASIZE;
    localparam logic [ASIZE-1:0] LAST_IDX = ASIZE'(NREG - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t             state_reg;
    logic [ASIZE-1:0]   cnt_reg;
    logic               ready_reg;
    logic [DSIZE-1:0]   regdata [0:NREG-1];
    logic [NREG-1:0]    busy_reg;

    // Constant lookup of which addresses name a real, writable register
    // (not r0 and below NREG). A table avoids range compares that collapse
    // to constants when NREG == 2**ASIZE.
    logic [NADDR-1:0]   addr_ok;

    generate
        for (genvar gi = 0; gi < NADDR; gi++) begin : g_addr_ok
            assign addr_ok[gi] = ((gi != 0) && (gi < NREG)) ? 1'b1 : 1'b0;
        end
    endgenerate

    logic run;
    logic wr0_ok;
    logic wr1_ok;
    logic set_ok;

    assign run    = (state_reg == ST_RUN);
    assign wr0_ok = run && wen0 && addr_ok[waddr0];
    assign wr1_ok = run && wen1 && addr_ok[waddr1];
    assign set_ok = run && set_en && addr_ok[set_addr];
    assign ready  = ready_reg;

    // Clear sequencer: one entry per cycle, ready registered on entry to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_CLEAR;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    if (cnt_reg == LAST_IDX) begin
                        state_reg <= ST_RUN;
                        ready_reg <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + ASIZE'(1);
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset of its own; the sequencer zeroes it entry by entry.
    // Port 1 is written last so it overrides port 0 on an address clash.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                regdata[cnt_reg] <= '0;
            end else begin
                if (wr0_ok) begin
                    regdata[waddr0] <= wdata0;
                end
                if (wr1_ok) begin
                    regdata[waddr1] <= wdata1;
                end
            end
        end
    end

    // Busy scoreboard: issue (set) beats writeback (clear) on the same entry
    // because the issuing instruction is the newer producer. Bit 0 can never
    // be set since addr_ok excludes address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (set_ok && (set_addr == ASIZE'(r))) begin
                    busy_reg[r] <= 1'b1;
                end else if ((wr0_ok && (waddr0 == ASIZE'(r))) ||
                             (wr1_ok && (waddr1 == ASIZE'(r)))) begin
                    busy_reg[r] <= 1'b0;
                end
            end
        end
    end

    // Read ports: zero for invalid addresses or while clearing, otherwise
    // bypass from the in-flight writes (port 1 first), else the stored value.
    // A bypassed read carries valid data, so it never reports a hazard.
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [ASIZE-1:0] ra;
            logic             ok;
            logic             hit0;
            logic             hit1;

            assign ra   = raddr[gi*ASIZE +: ASIZE];
            assign ok   = run && addr_ok[ra];
            assign hit1 = wr1_ok && (waddr1 == ra);
            assign hit0 = wr0_ok && (waddr0 == ra);

            assign rdata[gi*DSIZE +: DSIZE] = !ok  ? '0     :
                                              hit1 ? wdata1 :
                                              hit0 ? wdata0 :
                                              regdata[ra];
            assign rbusy[gi] = ok && busy_reg[ra] && !(hit0 || hit1);
        end
    endgenerate

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the next-generation pipeline.
- NRD combinational read ports and two prioritised write ports.
- Hardwired-zero register 0 and write-to-read bypass on every read port.
- A per-register busy scoreboard for load-use and writeback hazard detection.
- A sequential post-reset clear sequencer, so the array maps to RAM-friendly single-entry-per-cycle writes instead of a parallel reset.

Parameters:
DSIZE, 32, data width in bits
ASIZE, 5, register address width
NREG, 32, number of registers (NREG <= 2**ASIZE, NREG >= 2)
NRD, 3, number of read ports (1..4)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ready  out  1  high once the clear sequence is done; file usable
wen0  in  1  write enable, port 0 (ALU writeback)
waddr0  in  ASIZE  write address, port 0
wdata0  in  DSIZE  write data, port 0
wen1  in  1  write enable, port 1 (load writeback; higher priority)
waddr1  in  ASIZE  write address, port 1
wdata1  in  DSIZE  write data, port 1
set_en  in  1  mark a destination busy (instruction issue)
set_addr  in  ASIZE  register to mark busy
raddr  in  NRD*ASIZE  read addresses; port i is at bits [i*ASIZE +: ASIZE]
rdata  out  NRD*DSIZE  read data; port i is at bits [i*DSIZE +: DSIZE]
rbusy  out  NRD  per-read-port hazard flag

Behaviour:
- Reset (rst=1 at posedge clk):
  - FSM enters CLEAR, clear counter = 0, ready = 0.
  - All busy bits are cleared in the same cycle.
  - rst held high keeps the FSM in CLEAR with counter = 0.
  - rst asserted mid-CLEAR or mid-RUN restarts the sequence.
- CLEAR state:
  - Each cycle writes regdata[counter] = 0, then counter increments.
  - After writing entry NREG-1 the FSM goes to RUN and ready = 1 on the following cycle.
  - ready therefore rises exactly NREG cycles after the first clock with rst low.
- During CLEAR:
  - wen0, wen1 and set_en are ignored.
  - rdata = 0 and rbusy = 0 on all ports.
- RUN state, writes (registered at posedge):
  - Writes to address 0 or to any address >= NREG are dropped.
  - wen0 and wen1 to the same address: port 1 data is stored; port 0 is discarded.
  - wen0 and wen1 to different addresses: both are stored.
- RUN state, reads (combinational, zero latency):
  - raddr_i = 0 or >= NREG -> rdata_i = 0.
  - Else if wen1 && waddr1 == raddr_i -> wdata1.
  - Else if wen0 && waddr0 == raddr_i -> wdata0.
  - Else -> regdata[raddr_i].
  - All NRD ports are independent; any number may read the same address.
- Scoreboard (one busy bit per register; register 0 is never busy):
  - Busy bit is set at posedge when set_en && set_addr == r (r != 0, r < NREG).
  - Busy bit is cleared at posedge when a valid write (either port) hits r.
  - set_en and a write to the same r in the same cycle: set wins, so the bit ends up 1 (new producer).
- rbusy_i = busy[raddr_i] && !(a write this cycle hits raddr_i). Bypassed data is valid, so no hazard is flagged.
- rbusy_i = 0 for address 0 and for addresses >= NREG.
- There is no initial block; reset alone defines all state.

Test Plan:
- Reset, NREG=32: rst high 2 cycles, then low -> ready=0 for 32 cycles, ready=1 on cycle 33; a read of r7 returns 0; a wen0 issued on cycle 5 leaves r5 at 0.
- After ready: wen0 r3=0x11 and wen1 r3=0x22 in the same cycle -> rdata0 shows 0x22 combinationally that cycle; r3 holds 0x22 the next cycle.
- Write r0=0xFFFF and read r0 on all ports -> rdata=0 on every port, both during the write and afterwards.
- set_en r9 -> next cycle rbusy=1 on a port reading r9; wen1 r9=0xAB that cycle -> rbusy=0 and rdata=0xAB; following cycle busy cleared, r9=0xAB.
- set_en r4 and wen0 r4=0x5 in the same cycle -> r4=0x5 stored and busy[r4]=1 afterwards.
- Reset asserted mid-RUN with busy r2 and r2=0x77 -> busy cleared immediately, ready drops, r2 reads 0 for the whole CLEAR sequence and stores 0 after it.
